// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl: built-in self-test controller for the c17 NAND2 netlist.
// A 5-bit LFSR (x^5+x^3+1) drives the c17 inputs, and an 8-bit MISR
// (x^8+x^6+x^5+x^4+1) compacts the two c17 outputs. After the run, the final
// signature is compared against GOLDEN_SIG.
// Optional feature macro: C17_BIST_ZERO_VEC_EN. When it is defined, the
// all-zero vector is applied once before the LFSR sequence.
module c17_bist_ctrl #(
    parameter int unsigned NUM_PATTERNS = 31,      // 1..255
    parameter logic [4:0]  LFSR_SEED    = 5'h1F,   // must be non-zero
    parameter logic [7:0]  MISR_SEED    = 8'h00,
    parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [4:0] tpg,
    input  logic [1:0] resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] sig
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StCmp  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [7:0] LastCnt = 8'(NUM_PATTERNS - 1);

    logic [1:0] state_q, state_d;
    logic [4:0] lfsr_q, lfsr_d;
    logic [7:0] misr_q, misr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pass_q, pass_d;
    logic [4:0] lfsr_step;
    logic [7:0] misr_step;
`ifdef C17_BIST_ZERO_VEC_EN
    // High during the single zero-vector cycle at the start of a run.
    logic       zv_q, zv_d;
`endif

    // One step of the pattern generator and the response compactor.
    always_comb begin
        lfsr_step = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
        misr_step = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3]}
                    ^ {6'b0, resp};
    end

    // Next-state logic; abort overrides both start and run progress.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
`ifdef C17_BIST_ZERO_VEC_EN
        zv_d    = zv_q;
`endif
        if (abort) begin
            // The signature is kept so a partial run can still be inspected.
            state_d = StIdle;
            lfsr_d  = 5'h00;
            pass_d  = 1'b0;
`ifdef C17_BIST_ZERO_VEC_EN
            zv_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StRun;
                        misr_d  = MISR_SEED;
                        cnt_d   = 8'd0;
                        pass_d  = 1'b0;
`ifdef C17_BIST_ZERO_VEC_EN
                        // TPG stays a plain flop: zero first, then the seed.
                        lfsr_d  = 5'h00;
                        zv_d    = 1'b1;
`else
                        lfsr_d  = LFSR_SEED;
`endif
                    end
                end
                StRun: begin
                    misr_d = misr_step;
`ifdef C17_BIST_ZERO_VEC_EN
                    if (zv_q) begin
                        // The zero vector does not count as an LFSR pattern.
                        lfsr_d = LFSR_SEED;
                        zv_d   = 1'b0;
                    end else begin
                        lfsr_d = lfsr_step;
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q == LastCnt) begin
                            state_d = StCmp;
                        end
                    end
`else
                    lfsr_d = lfsr_step;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == LastCnt) begin
                        state_d = StCmp;
                    end
`endif
                end
                StCmp: begin
                    pass_d  = (misr_q == GOLDEN_SIG);
                    state_d = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            lfsr_q  <= 5'h00;
            misr_q  <= 8'h00;
            cnt_q   <= 8'd0;
            pass_q  <= 1'b0;
`ifdef C17_BIST_ZERO_VEC_EN
            zv_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
`ifdef C17_BIST_ZERO_VEC_EN
            zv_q    <= zv_d;
`endif
        end
    end

    // Outputs decoded from state; pass_q is cleared whenever DONE is left.
    always_comb begin
        tpg  = lfsr_q;
        sig  = misr_q;
        busy = (state_q == StRun) || (state_q == StCmp);
        done = (state_q == StDone);
        pass = pass_q & done;
    end

endmodule
